// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t : sequencer FSM states
//   addr_t        : instruction word address (64-word memory)
//   instr_t       : instruction word
//   NOP_WORD      : encoding squashed when FETCH_NOP_SQUASH_EN is defined
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t  LAST_ADDR = 6'd63;
  localparam instr_t NOP_WORD  = 32'h0007_8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Program counter and fetch controller for the 64-word instruction memory.
// Drives the memory word address, captures the returned word into a
// one-entry buffer and hands it to decode over valid/ready.
//
// Ports
//   clk, reset      : clock (rising edge), asynchronous active-high reset
//   run             : level, fetch continuously while high
//   step            : one-cycle pulse, fetch one word (honoured in IDLE only)
//   branch_valid    : one-cycle redirect request
//   branch_target   : redirect address
//   count           : registered PC, address to instruction memory
//   mem_instr       : combinational memory data for count
//   instr_out       : buffered instruction to decode
//   instr_pc        : address instr_out was fetched from
//   instr_valid     : instr_out holds an unconsumed word
//   instr_ready     : decode accepts (transfer = valid & ready)
//   busy            : state is RUN or STEP
//   done            : state is DONE
//
// Build option
//   FETCH_NOP_SQUASH_EN : fetched NOP_WORD is dropped instead of buffered;
//                         the PC still advances and the LAST_ADDR stop holds.
//
// States
//   IDLE | waiting for run/step; a branch only reloads the PC
//   RUN  | fetching every cycle the buffer can take a word
//   STEP | fetching a single word, then back to IDLE
//   DONE | LAST_ADDR fetched; leaves only on branch or reset
// ---------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   run,
  input  logic   step,
  input  logic   branch_valid,
  input  addr_t  branch_target,
  output addr_t  count,
  input  instr_t mem_instr,
  output instr_t instr_out,
  output addr_t  instr_pc,
  output logic   instr_valid,
  input  logic   instr_ready,
  output logic   busy,
  output logic   done
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  addr_t  r_count;
  instr_t r_instr;
  addr_t  r_pc;
  logic   r_valid;

  logic w_active;
  logic w_fetch;
  logic w_xfer;
  logic w_load;
  logic w_at_last;

  assign w_active  = (r_state == RUN) || (r_state == STEP);
  // A fetch needs an empty buffer or one being drained this same cycle;
  // a branch cycle never fetches because count is being redirected.
  assign w_fetch   = w_active && !branch_valid && (!r_valid || instr_ready);
  assign w_xfer    = r_valid && instr_ready;
  assign w_at_last = (r_count == LAST_ADDR);

`ifdef FETCH_NOP_SQUASH_EN
  assign w_load = w_fetch && (mem_instr != NOP_WORD);
`else
  assign w_load = w_fetch;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        // branch wins over run/step: IDLE only reloads the PC that cycle
        if (!branch_valid) begin
          if (run) begin
            w_state_nxt = RUN;
          end else if (step) begin
            w_state_nxt = STEP;
          end
        end
      end
      RUN: begin
        if (w_fetch && w_at_last) begin
          w_state_nxt = DONE;
        end else if (!run) begin
          w_state_nxt = IDLE;
        end
      end
      STEP: begin
        if (w_fetch) begin
          w_state_nxt = w_at_last ? DONE : IDLE;
        end
      end
      DONE: begin
        if (branch_valid) begin
          w_state_nxt = run ? RUN : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (branch_valid) begin
      // flush: a same-cycle transfer was already accepted by decode
      r_count <= branch_target;
      r_valid <= 1'b0;
    end else begin
      // PC saturates at LAST_ADDR rather than wrapping
      if (w_fetch && !w_at_last) begin
        r_count <= r_count + 1'b1;
      end
      if (w_load) begin
        r_instr <= mem_instr;
        r_pc    <= r_count;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign count       = r_count;
  assign instr_out   = r_instr;
  assign instr_pc    = r_pc;
  assign instr_valid = r_valid;
  assign busy        = w_active;
  assign done        = (r_state == DONE);

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. A behavioural 64-word memory
// feeds mem_instr; every word decode should receive is queued in order and
// compared when a transfer (valid & ready) is seen on the falling edge.
// Inputs change 1 time unit after the rising edge; direct checks are made
// at that point too.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
  import fetch_pkg::*;

  typedef struct packed {
    addr_t  pc;
    instr_t word;
  } sb_item_t;

  logic   clk;
  logic   reset;
  logic   run;
  logic   step;
  logic   branch_valid;
  addr_t  branch_target;
  addr_t  count;
  instr_t mem_instr;
  instr_t instr_out;
  addr_t  instr_pc;
  logic   instr_valid;
  logic   instr_ready;
  logic   busy;
  logic   done;

  instr_t   mem [64];
  sb_item_t sb_q[$];
  int       n_cmp;
  int       n_err;
  bit       seen_done;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .step          (step),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .count         (count),
    .mem_instr     (mem_instr),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_instr = mem[count];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue one expected transfer; squashed builds never present NOPs.
  task automatic push_pc(input int a);
    sb_item_t it;
    it.pc   = addr_t'(a);
    it.word = mem[a];
`ifdef FETCH_NOP_SQUASH_EN
    if (it.word != NOP_WORD) sb_q.push_back(it);
`else
    sb_q.push_back(it);
`endif
  endtask

  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pc", 32'(instr_pc), 32'hFFFF_FFFF);
      end else begin
        sb_item_t e;
        e = sb_q.pop_front();
        chk("sb_pc", 32'(instr_pc), 32'(e.pc));
        chk("sb_word", instr_out, e.word);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 0 || i >= 10) mem[i] = NOP_WORD;
      else                   mem[i] = 32'hA000_0000 | 32'(i);
    end
    mem[1] = 32'h8008_0001;
    mem[2] = 32'h8210_0001;
    mem[7] = 32'h8030_0006;

    reset = 1'b1; run = 1'b0; step = 1'b0; branch_valid = 1'b0;
    branch_target = '0; instr_ready = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_out", instr_out, 0);
    chk("rst_busy_done", {30'd0, busy, done}, 0);

    // continuous run with decode always ready
    reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
    push_pc(0); push_pc(1);
    tick();
    chk("run_enter_busy", 32'(busy), 1);
    chk("run_enter_count", 32'(count), 0);
    tick();
    chk("run_count1", 32'(count), 1);
`ifndef FETCH_NOP_SQUASH_EN
    chk("run_word0_valid", 32'(instr_valid), 1);
    chk("run_word0", instr_out, 32'h0007_8000);
`endif
    tick();
    chk("run_count2", 32'(count), 2);
    tick();
    chk("run_count3", 32'(count), 3);
    chk("run_pc2", 32'(instr_pc), 2);

    // back-pressure for three edges
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_count", 32'(count), 3);
      chk("bp_word", instr_out, 32'h8210_0001);
      chk("bp_valid", 32'(instr_valid), 1);
    end
    push_pc(2);
    instr_ready = 1'b1;
    tick();
    chk("bp_resume_pc", 32'(instr_pc), 3);
    chk("bp_resume_count", 32'(count), 4);

    // branch to 7 while pc 3 is buffered; pc 3 is still accepted
    push_pc(3);
    branch_valid = 1'b1; branch_target = 6'd7;
    tick();
    chk("br_flush_valid", 32'(instr_valid), 0);
    chk("br_count", 32'(count), 7);
    branch_valid = 1'b0;
    push_pc(7);
    tick();
    chk("br_target_pc", 32'(instr_pc), 7);
    chk("br_target_word", instr_out, 32'h8030_0006);
    chk("br_count8", 32'(count), 8);

    // leave RUN via a branch to 1 with run low
    run = 1'b0; branch_valid = 1'b1; branch_target = 6'd1;
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_count", 32'(count), 1);
    branch_valid = 1'b0;

    // single step from IDLE
    step = 1'b1;
    push_pc(1);
    tick();
    step = 1'b0;
    chk("step_busy", 32'(busy), 1);
    tick();
    chk("step_count", 32'(count), 2);
    chk("step_back_idle", 32'(busy), 0);
    chk("step_valid", 32'(instr_valid), 1);
    tick();
    chk("step_drained", 32'(instr_valid), 0);
    tick();
    chk("step_count_hold", 32'(count), 2);

    // run to the end of the program, with a stray step pulse in RUN
    run = 1'b1;
    for (int a = 2; a < 64; a++) push_pc(a);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_in_run_ignored", 32'(busy), 1);
    for (int i = 0; i < 200 && !seen_done; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("done_reached", 32'(seen_done), 1);
    chk("done_count", 32'(count), 63);
`ifndef FETCH_NOP_SQUASH_EN
    chk("done_last_pc", 32'(instr_pc), 63);
`endif
    tick();
    chk("done_valid_clear", 32'(instr_valid), 0);
    tick(); tick();
    chk("done_hold", 32'(done), 1);
    chk("done_count_hold", 32'(count), 63);

    // restart from DONE with a branch to 0 while run is high
    branch_valid = 1'b1; branch_target = 6'd0;
    tick();
    branch_valid = 1'b0;
    instr_ready = 1'b0;
    chk("restart_busy_done", {30'd0, busy, done}, 32'h2);
    chk("restart_count", 32'(count), 0);
    tick();
    chk("restart_count1", 32'(count), 1);
`ifndef FETCH_NOP_SQUASH_EN
    chk("restart_valid", 32'(instr_valid), 1);
`endif
    tick();
    chk("restart_stall", 32'(count), 1);

    // asynchronous reset mid-cycle with a word stuck in the buffer
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_valid", 32'(instr_valid), 0);
    chk("async_out", instr_out, 0);
    chk("async_pc", 32'(instr_pc), 0);
    chk("async_busy_done", {30'd0, busy, done}, 0);
    run = 1'b0;
    tick();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_sequencer
